// File: rtl/sectionalizer_pkg.sv
// Shared state encoding, widths and default parameters for the sectionalizer controller.
package sectionalizer_pkg;

  localparam int DEF_NUM_CH   = 600;
  localparam int DEF_INIT_CYC = 600;
  localparam int DEF_STEP_CYC = 4;
  localparam int DEF_DONE_TMO = 15;

  localparam int ADDR_W  = 10;
  localparam int PHASE_W = 2;
  localparam int TMR_W   = 16;

  localparam logic [PHASE_W-1:0] FINAL_PHASE = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_SYNC
  } sect_state_e;

endpackage

// File: rtl/sect_wait_timer.sv
// Loadable down-counter; expired_o marks the last counted cycle, idle_o means nothing is loaded.
module sect_wait_timer
  import sectionalizer_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o,
  output logic         idle_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == W'(1));
  assign idle_o    = (cnt_q == '0);

endmodule

// File: rtl/sectionalizer_ctrl.sv
// Sequences one input bit per channel into the sectionalizer datapath and reports
// final-phase decisions; one shared timer covers the init wait, step wait and done timeout.
module sectionalizer_ctrl
  import sectionalizer_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int INIT_CYC = DEF_INIT_CYC,
  parameter int STEP_CYC = DEF_STEP_CYC,
  parameter int DONE_TMO = DEF_DONE_TMO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               in_ready,
  output logic               sect_start,
  output logic [ADDR_W-1:0]  sect_addr,
  output logic               sect_ibits,
  output logic               sect_synclk,
  input  logic               sect_done,
  input  logic               sect_obits,
  output logic               sect_rst_n,
  output logic               out_valid,
  output logic               out_bit,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [PHASE_W-1:0] phase,
  output logic               tmo_err
);

  // Zero-length waits would never expire, so they are stretched to one cycle.
  localparam logic [ADDR_W-1:0] LAST_CH   = ADDR_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0]  INIT_LOAD = TMR_W'(INIT_CYC);
  localparam logic [TMR_W-1:0]  STEP_LOAD = TMR_W'((STEP_CYC < 1) ? 1 : STEP_CYC);
  localparam logic [TMR_W-1:0]  TMO_LOAD  = TMR_W'((DONE_TMO < 1) ? 1 : DONE_TMO);

  sect_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  chan_q, chan_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               ibits_q, ibits_d;
  logic               outValid_q, outValid_d;
  logic               outBit_q, outBit_d;
  logic [ADDR_W-1:0]  outAddr_q, outAddr_d;
  logic               tmo_q, tmo_d;

  logic               tmrLoad;
  logic [TMR_W-1:0]   tmrValue;
  logic               tmrExpired;
  logic               tmrIdle;
  logic               finalPhase;
  logic               advance;

  assign finalPhase = (phase_q == FINAL_PHASE);

  sect_wait_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (tmrLoad),
    .value_i   (tmrValue),
    .expired_o (tmrExpired),
    .idle_o    (tmrIdle)
  );

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    phase_d    = phase_q;
    ibits_d    = ibits_q;
    outValid_d = 1'b0;
    outBit_d   = outBit_q;
    outAddr_d  = outAddr_q;
    tmo_d      = tmo_q;
    tmrLoad    = 1'b0;
    tmrValue   = STEP_LOAD;
    advance    = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        // The timer is still empty on the first cycle out of reset; arm it once.
        if (INIT_CYC == 0 || tmrExpired) begin
          state_d = ST_IDLE;
        end else if (tmrIdle) begin
          tmrLoad  = 1'b1;
          tmrValue = INIT_LOAD;
        end
      end
      ST_IDLE: begin
        if (in_valid) begin
          ibits_d = in_bit;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tmrLoad  = 1'b1;
        tmrValue = finalPhase ? TMO_LOAD : STEP_LOAD;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (finalPhase) begin
          if (sect_done) begin
            outValid_d = 1'b1;
            outBit_d   = sect_obits;
            outAddr_d  = chan_q;
            advance    = 1'b1;
          end else if (tmrExpired) begin
            tmo_d   = 1'b1;
            advance = 1'b1;
          end
        end else if (tmrExpired) begin
          advance = 1'b1;
        end
      end
      ST_SYNC: begin
        chan_d  = '0;
        phase_d = phase_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    if (advance) begin
      if (chan_q < LAST_CH) begin
        chan_d  = chan_q + 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_SYNC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      chan_q     <= '0;
      phase_q    <= '0;
      ibits_q    <= 1'b0;
      outValid_q <= 1'b0;
      outBit_q   <= 1'b0;
      outAddr_q  <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      phase_q    <= phase_d;
      ibits_q    <= ibits_d;
      outValid_q <= outValid_d;
      outBit_q   <= outBit_d;
      outAddr_q  <= outAddr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign sect_start  = (state_q == ST_START);
  assign sect_synclk = (state_q == ST_SYNC);
  assign sect_addr   = chan_q;
  assign sect_ibits  = ibits_q;
  assign sect_rst_n  = ~reset;
  assign out_valid   = outValid_q;
  assign out_bit     = outBit_q;
  assign out_addr    = outAddr_q;
  assign phase       = phase_q;
  assign tmo_err     = tmo_q;

endmodule

// File: tb/tb_sectionalizer_ctrl.sv
// Randomized bench: a timestamp-based reference model checks every output each cycle,
// plus literal checks on init latency, frame counts, the addr 5 result and the addr 7 timeout.
`timescale 1ns/1ps
module tb_sectionalizer_ctrl;

  localparam int NUM_CH   = 600;
  localparam int INIT_CYC = 600;
  localparam int STEP_CYC = 4;
  localparam int DONE_TMO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       sect_done = 1'b0;
  logic       sect_obits = 1'b0;
  logic       in_ready, sect_start, sect_ibits, sect_synclk, sect_rst_n;
  logic       out_valid, out_bit, tmo_err;
  logic [9:0] sect_addr, out_addr;
  logic [1:0] phase;

  int errors = 0;
  int checks = 0;
  bit finished = 0;

  // reference model state (cycle numbers counted from reset release)
  int p = 0, tStart = -1, syncAt = -1, outAt = -1, tmoFrom = -1;
  int chan = 0, ph = 0, heldAddr = 0, pendAddr = 0;
  bit act = 0, ibit = 0, heldBit = 0, pendBit = 0;

  // observations for the literal checks
  int  frameCnt = 0, firstStartP = -1, firstStartAddr = -1, readyLowCnt = 0;
  bit  sawReady = 0, afterReset = 0, capPhase = 0, want8 = 0;
  int  startsF0 = 0, ovA = 0, ovNonFinal = 0, ov5Cnt = 0, ov5Bit = -1;
  int  syncSeen = 0, start7P = -1, tmoRiseP = -1, tmoRiseFrame = -1, addrAfter7 = -1;
  int  phaseAfterSync [4];

  sectionalizer_ctrl #(
    .NUM_CH   (NUM_CH),
    .INIT_CYC (INIT_CYC),
    .STEP_CYC (STEP_CYC),
    .DONE_TMO (DONE_TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .sect_start  (sect_start),
    .sect_addr   (sect_addr),
    .sect_ibits  (sect_ibits),
    .sect_synclk (sect_synclk),
    .sect_done   (sect_done),
    .sect_obits  (sect_obits),
    .sect_rst_n  (sect_rst_n),
    .out_valid   (out_valid),
    .out_bit     (out_bit),
    .out_addr    (out_addr),
    .phase       (phase),
    .tmo_err     (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic finishRun();
    if (!finished) begin
      finished = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
      if (errors >= 40) finishRun();
    end
  endtask

  task automatic modelReset();
    p = 0; act = 0; tStart = -1; syncAt = -1; outAt = -1; tmoFrom = -1;
    chan = 0; ph = 0; ibit = 0; heldBit = 0; heldAddr = 0; pendBit = 0; pendAddr = 0;
    firstStartP = -1; firstStartAddr = -1; readyLowCnt = 0; sawReady = 0;
  endtask

  // Per-cycle comparison against the model, then model advance from this cycle's inputs.
  always @(negedge clk) begin : compare
    bit expSync, expStart, expReady, expOv, expTmo, exitNow;
    int w;
    if (reset) begin
      checkOutput("rst_in_ready", int'(in_ready), 0);
      checkOutput("rst_sect_start", int'(sect_start), 0);
      checkOutput("rst_sect_addr", int'(sect_addr), 0);
      checkOutput("rst_sect_ibits", int'(sect_ibits), 0);
      checkOutput("rst_sect_synclk", int'(sect_synclk), 0);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_out_bit", int'(out_bit), 0);
      checkOutput("rst_out_addr", int'(out_addr), 0);
      checkOutput("rst_phase", int'(phase), 0);
      checkOutput("rst_tmo_err", int'(tmo_err), 0);
      checkOutput("rst_sect_rst_n", int'(sect_rst_n), 0);
      modelReset();
    end else begin
      p++;
      if (p == outAt) begin
        heldBit  = pendBit;
        heldAddr = pendAddr;
      end
      expSync  = (p == syncAt);
      expStart = act && (p == tStart);
      expReady = (p > INIT_CYC) && !act && !expSync;
      expOv    = (p == outAt);
      expTmo   = (tmoFrom >= 0) && (p >= tmoFrom);

      checkOutput("in_ready", int'(in_ready), int'(expReady));
      checkOutput("sect_start", int'(sect_start), int'(expStart));
      checkOutput("sect_addr", int'(sect_addr), chan);
      checkOutput("sect_ibits", int'(sect_ibits), int'(ibit));
      checkOutput("sect_synclk", int'(sect_synclk), int'(expSync));
      checkOutput("out_valid", int'(out_valid), int'(expOv));
      checkOutput("out_bit", int'(out_bit), int'(heldBit));
      checkOutput("out_addr", int'(out_addr), heldAddr);
      checkOutput("phase", int'(phase), ph);
      checkOutput("tmo_err", int'(tmo_err), int'(expTmo));
      checkOutput("sect_rst_n", int'(sect_rst_n), 1);

      if (!sawReady) begin
        if (in_ready) sawReady = 1;
        else readyLowCnt++;
      end
      if (sect_start && firstStartP < 0) begin
        firstStartP    = p;
        firstStartAddr = int'(sect_addr);
      end
      if (!afterReset) begin
        if (capPhase) begin
          phaseAfterSync[syncSeen] = int'(phase);
          syncSeen++;
          capPhase = 0;
        end
        if (sect_start && frameCnt == 0) startsF0++;
        if (out_valid && frameCnt <= 3) ovA++;
        if (out_valid && frameCnt == 3 && out_addr == 10'd5) begin
          ov5Cnt++;
          ov5Bit = int'(out_bit);
        end
        if (want8 && sect_start) begin
          addrAfter7 = int'(sect_addr);
          want8 = 0;
        end
        if (frameCnt == 7 && sect_start && sect_addr == 10'd7) begin
          start7P = p;
          want8   = 1;
        end
        if (tmo_err && tmoRiseP < 0) begin
          tmoRiseP     = p;
          tmoRiseFrame = frameCnt;
        end
      end
      if (out_valid && phase != 2'd3) ovNonFinal++;
      if (sect_synclk) begin
        frameCnt++;
        if (!afterReset && syncSeen < 4) capPhase = 1;
      end

      if (expReady && in_valid) begin
        act    = 1;
        tStart = p + 1;
        ibit   = in_bit;
      end else if (act && p > tStart) begin
        w = p - tStart;
        exitNow = 0;
        if (ph != 3) begin
          exitNow = (w == STEP_CYC);
        end else if (sect_done) begin
          exitNow  = 1;
          outAt    = p + 1;
          pendBit  = sect_obits;
          pendAddr = chan;
        end else if (w == DONE_TMO) begin
          exitNow = 1;
          if (tmoFrom < 0) tmoFrom = p + 1;
        end
        if (exitNow) begin
          act = 0;
          if (chan < NUM_CH - 1) chan++;
          else syncAt = p + 1;
        end
      end
      if (expSync) begin
        chan = 0;
        ph   = (ph + 1) % 4;
      end
    end
  end

  // Upstream source: holds data until accepted, otherwise offers random bits.
  initial begin : applyStimulus
    bit acc;
    forever begin
      @(negedge clk);
      acc = in_valid && in_ready && !reset;
      @(posedge clk);
      #1;
      if (reset) begin
        in_valid = 1'b1;
      end else if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 9) != 0);
        in_bit   = 1'($urandom_range(0, 1));
      end
    end
  end

  // Datapath stand-in: answers each start after a chosen delay, with noise where it must be ignored.
  initial begin : datapath
    int cnt;
    bit schedBit, fire;
    cnt = 0;
    schedBit = 0;
    forever begin
      @(posedge clk);
      #1;
      fire = 0;
      if (reset) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        fire = (cnt == 0);
      end
      if (fire) begin
        sect_done  = 1'b1;
        sect_obits = schedBit;
      end else begin
        sect_obits = 1'($urandom_range(0, 1));
        if (!reset && (phase != 2'd3 || sect_start || in_ready || sect_synclk))
          sect_done = ($urandom_range(0, 3) == 0);
        else
          sect_done = 1'b0;
      end
      @(negedge clk);
      if (!reset && sect_start) begin
        schedBit = 1'($urandom_range(0, 1));
        if (afterReset || frameCnt <= 3) begin
          if (phase == 2'd3 && sect_addr == 10'd5) begin
            cnt = 6;
            schedBit = 1'b1;
          end else begin
            cnt = $urandom_range(1, DONE_TMO);
          end
        end else if (phase == 2'd3 && sect_addr == 10'd7) begin
          cnt = 0;
        end else if (phase == 2'd3 && sect_addr < 10'd7) begin
          cnt = $urandom_range(1, DONE_TMO);
        end else begin
          cnt = $urandom_range(1, DONE_TMO + 5);
        end
      end
    end
  end

  task automatic checkRelease();
    int n;
    n = 0;
    while (firstStartP < 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("first_start_cycle", firstStartP, 602);
    checkOutput("first_start_addr", firstStartAddr, 0);
    checkOutput("init_ready_low_cycles", readyLowCnt, 600);
  endtask

  initial begin : main
    bit ok;
    int n;
    in_valid = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    $display("[TB] reset released, running frames");
    checkRelease();

    ok = 0;
    n = 0;
    while (!ok && n < 80000) begin
      @(negedge clk);
      n++;
      if (frameCnt == 10 && phase == 2'd2 && sect_start && sect_addr == 10'd300) ok = 1;
    end
    checkOutput("reached_phase2_addr300", int'(ok), 1);
    if (!ok) finishRun();

    checkOutput("frame0_start_count", startsF0, 600);
    checkOutput("frames0to3_out_valid_count", ovA, 600);
    checkOutput("out_valid_outside_phase3", ovNonFinal, 0);
    checkOutput("addr5_result_count", ov5Cnt, 1);
    checkOutput("addr5_result_bit", ov5Bit, 1);
    checkOutput("phase_after_sync1", phaseAfterSync[0], 1);
    checkOutput("phase_after_sync2", phaseAfterSync[1], 2);
    checkOutput("phase_after_sync3", phaseAfterSync[2], 3);
    checkOutput("phase_after_sync4", phaseAfterSync[3], 0);
    checkOutput("tmo_first_frame", tmoRiseFrame, 7);
    checkOutput("tmo_delay_from_addr7_start", tmoRiseP - start7P, 16);
    checkOutput("start_after_addr7", addrAfter7, 8);
    checkOutput("tmo_err_before_reset", int'(tmo_err), 1);

    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready", int'(in_ready), 0);
    checkOutput("midrst_sect_start", int'(sect_start), 0);
    checkOutput("midrst_sect_addr", int'(sect_addr), 0);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_phase", int'(phase), 0);
    checkOutput("midrst_tmo_err", int'(tmo_err), 0);
    afterReset = 1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    checkRelease();
    repeat (200) @(negedge clk);
    finishRun();
  end

endmodule
